// File: rtl/program_loader.sv
// program_loader: boot loader that writes a framed byte-stream image into instruction memory and holds the CPU in reset until a checksum-valid load.
// Frame: HEADER_BYTE, LEN (0 means 256 words), LEN words sent high byte first, then CSUM.
// CSUM is the XOR of all payload bytes.
// Ports: clock/reset (async, active-high); rx_data/rx_valid/rx_ready byte input (never stalls);
//   imem_we/imem_addr/imem_wdata one-cycle memory write; cpu_reset/load_done/load_error status;
//   words_loaded counts the writes made in the current or last frame.
// Optional: define LOADER_TIMEOUT_EN to abort a frame into the error state after
//   TIMEOUT_CYCLES idle cycles between bytes.
module program_loader #(
  parameter logic [7:0] HEADER_BYTE = 8'hA5
`ifdef LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_error,
  output logic [8:0]  words_loaded
);
  typedef enum logic [2:0] {IDLE, LEN, HI, LO, CSUM, DONE, ERR} state_t;
  state_t state, state_d;
  logic [8:0] n_words;
  logic [7:0] hi_byte, csum;
  logic acc, hdr, last;
  assign rx_ready = 1'b1;
  assign acc = rx_valid & rx_ready;
  assign hdr = acc && rx_data == HEADER_BYTE;
  // words_loaded already includes every earlier word, so this LO byte completes word words_loaded+1
  assign last = words_loaded + 9'd1 == n_words;
  assign cpu_reset = state != DONE;
  assign load_done = state == DONE;
  assign load_error = state == ERR;
`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  logic active, tmo;
  assign active = state inside {LEN, HI, LO, CSUM};
  assign tmo = active && !acc && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) idle_cnt <= '0;
    else idle_cnt <= (acc || !active) ? '0 : idle_cnt + 1'b1;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE, ERR: state_d = hdr ? LEN : state;
      LEN:             state_d = acc ? HI : LEN;
      HI:              state_d = acc ? LO : HI;
      LO:              state_d = acc ? (last ? CSUM : HI) : LO;
      CSUM:            state_d = acc ? (rx_data == csum ? DONE : ERR) : CSUM;
      default:         state_d = IDLE;
    endcase
`ifdef LOADER_TIMEOUT_EN
    if (tmo) state_d = ERR;
`endif
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      n_words      <= '0;
      hi_byte      <= '0;
      csum         <= '0;
    end else begin
      imem_we <= acc && state == LO;
      if (acc && state == LEN) begin
        n_words      <= rx_data == 8'd0 ? 9'd256 : {1'b0, rx_data};
        imem_addr    <= '0;
        csum         <= '0;
        words_loaded <= '0;
      end
      if (acc && state == HI) begin
        hi_byte <= rx_data;
        csum    <= csum ^ rx_data;
      end
      if (acc && state == LO) begin
        imem_wdata <= {hi_byte, rx_data};
        csum       <= csum ^ rx_data;
      end
      // address advances after each write and parks at 8'hFF so word 256 lands there
      if (imem_we) begin
        words_loaded <= words_loaded + 9'd1;
        imem_addr    <= imem_addr == 8'hFF ? imem_addr : imem_addr + 8'd1;
      end
    end
endmodule
